// File: rtl/seg_pkg.sv
// Shared types and constants for the 3-digit BCD 7-segment display path.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with dp held off.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam int         NUM_DIGITS = 3;
  localparam logic [5:0] SEL_OFF    = 6'h3F;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Iterative double-dabble converter: 8 shift cycles plus one commit cycle.
// bcd is {hund, tens, ones} and is only meaningful while commit is high.
module bcd_seq_conv
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  a,
  output logic        busy,
  output logic        commit,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] adj;
  logic [19:0] pre_shift;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (sr_q[8 + gi*4 +: 4] >= 4'd5) ?
                              sr_q[8 + gi*4 +: 4] + 4'd3 : sr_q[8 + gi*4 +: 4];
    end
  endgenerate

  assign pre_shift = {adj, sr_q[7:0]};
  assign bcd       = sr_q[19:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_SHIFT;
      ST_SHIFT:  if (iter_q == 3'd7) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: the shadow nibbles sit above the binary byte in one register.
  always_comb begin
    sr_d   = sr_q;
    iter_d = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d   = {12'd0, a};
          iter_d = 3'd0;
        end
      end
      ST_SHIFT: begin
        sr_d   = pre_shift << 1;
        iter_d = iter_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    commit = (state_q == ST_COMMIT);
  end

endmodule

// File: rtl/seg_disp_ctrl.sv
// 3-digit display controller: converts a loaded byte to BCD, commits it
// atomically and scans the digits with leading-zero blanking.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] a,
  output logic       busy,
  output logic       done,
  output logic [5:0] seg_sel,
  output logic [7:0] seg_led
);

  localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic          conv_commit;
  logic [11:0]   conv_bcd;
  logic [11:0]   disp_q, disp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic          done_q, done_d;
  logic [5:0]    seg_sel_q, seg_sel_d;
  logic [7:0]    seg_led_q, seg_led_d;
  logic [NUM_DIGITS-1:0] blank;
  logic [7:0]    digit_code [NUM_DIGITS];

  bcd_seq_conv u_conv (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .a      (a),
    .busy   (busy),
    .commit (conv_commit),
    .bcd    (conv_bcd)
  );

  assign blank[0] = 1'b0;
  assign blank[1] = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
  assign blank[2] = (disp_q[11:8] == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
      assign digit_code[gi] = blank[gi] ? SEG_BLANK : seg_encode(disp_q[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q    <= '0;
      presc_q   <= '0;
      digit_q   <= '0;
      done_q    <= 1'b0;
      seg_sel_q <= 6'b111110;
      seg_led_q <= SEG_0;
    end else begin
      disp_q    <= disp_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      done_q    <= done_d;
      seg_sel_q <= seg_sel_d;
      seg_led_q <= seg_led_d;
    end
  end

  always_comb begin
    disp_d  = conv_commit ? conv_bcd : disp_q;
    done_d  = conv_commit;
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end
  end

  // Outputs register the current index/display, so they trail by one cycle.
  always_comb begin
    seg_sel_d = SEL_OFF & ~(6'd1 << digit_q);
    case (digit_q)
      2'd0:    seg_led_d = digit_code[0];
      2'd1:    seg_led_d = digit_code[1];
      2'd2:    seg_led_d = digit_code[2];
      default: seg_led_d = SEG_BLANK;
    endcase
  end

  assign done    = done_q;
  assign seg_sel = seg_sel_q;
  assign seg_led = seg_led_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl with SCAN_DIV=4: handshake timing,
// scanned digit codes, blanking, ignored/accepted loads and async reset.
module tb_seg_disp_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] a;
  logic       busy;
  logic       done;
  logic [5:0] seg_sel;
  logic [7:0] seg_led;

  int tests_run;
  int tests_failed;

  seg_disp_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .a       (a),
    .busy    (busy),
    .done    (done),
    .seg_sel (seg_sel),
    .seg_led (seg_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the slot of digit idx, then checks its segment code.
  task automatic check_digit(input string tag, input int idx, input logic [7:0] exp_led);
    logic [5:0] sel_exp;
    bit found;
    sel_exp = 6'h3F & ~(6'd1 << idx);
    found = 0;
    for (int i = 0; i < 3*SCAN_DIV + 4; i++) begin
      @(negedge clk);
      if (seg_sel == sel_exp) begin
        found = 1;
        break;
      end
    end
    if (!found) check({tag, " sel"}, {26'd0, seg_sel}, {26'd0, sel_exp});
    else        check(tag, {24'd0, seg_led}, {24'd0, exp_led});
  endtask

  task automatic check_display(input string tag, input logic [7:0] h, input logic [7:0] t,
                               input logic [7:0] o);
    check_digit({tag, " ones"}, 0, o);
    check_digit({tag, " tens"}, 1, t);
    check_digit({tag, " hund"}, 2, h);
  endtask

  // Loads val, optionally drives a second load at cycle inj_n, and observes
  // busy/done over a fixed window measured in cycles after the load edge.
  task automatic run_load(input string tag, input logic [7:0] val, input int inj_n,
                          input logic [7:0] inj_val, input int exp_busy, input int exp_dones);
    int bc, dc, fd;
    bc = 0; dc = 0; fd = 0;
    @(negedge clk);
    load = 1'b1;
    a    = val;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dc++;
        if (fd == 0) fd = n;
      end
      if (n == inj_n) begin
        load = 1'b1;
        a    = inj_val;
      end else begin
        load = 1'b0;
      end
    end
    $display("[TB] load a=%0d inject@%0d a=%0d: busy_cycles=%0d dones=%0d first_done=%0d",
             val, inj_n, inj_val, bc, dc, fd);
    check({tag, " busy_cycles"}, bc, exp_busy);
    check({tag, " done_count"}, dc, exp_dones);
    check({tag, " done_cycle"}, fd, 10);
  endtask

  initial begin
    int dc;
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b1;
    load = 1'b0;
    a    = 8'd0;

    repeat (2) @(negedge clk);
    check("rst seg_sel", {26'd0, seg_sel}, 32'h3E);
    check("rst seg_led", {24'd0, seg_led}, 32'hC0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst busy", {31'd0, busy}, 0);
    check("post-rst done", {31'd0, done}, 0);
    check_display("zero", 8'hFF, 8'hFF, 8'hC0);

    run_load("a255", 8'd255, 0, 8'd0, 9, 1);
    check_display("a255", 8'hA4, 8'h92, 8'h92);

    run_load("a7", 8'd7, 0, 8'd0, 9, 1);
    check_display("a7", 8'hFF, 8'hFF, 8'hF8);

    run_load("a105", 8'd105, 0, 8'd0, 9, 1);
    check_display("a105", 8'hF9, 8'hC0, 8'h92);

    // Second load on the 3rd busy cycle must be dropped.
    run_load("a42 ign99", 8'd42, 3, 8'd99, 9, 1);
    check_display("a42", 8'hFF, 8'h99, 8'hA4);

    // Second load during the done cycle must be accepted.
    run_load("a42 acc99", 8'd42, 10, 8'd99, 18, 2);
    check_display("a99", 8'hFF, 8'h90, 8'h90);

    run_load("a42 pre", 8'd42, 0, 8'd0, 9, 1);
    check_display("pre-rst", 8'hFF, 8'h99, 8'hA4);

    // Reset during the 5th shift cycle of a=200.
    @(negedge clk);
    load = 1'b1;
    a    = 8'd200;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      load = 1'b0;
    end
    check("mid busy before rst", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    check("mid-rst busy", {31'd0, busy}, 0);
    check("mid-rst done", {31'd0, done}, 0);
    check("mid-rst seg_sel", {26'd0, seg_sel}, 32'h3E);
    check("mid-rst seg_led", {24'd0, seg_led}, 32'hC0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (done) dc++;
    end
    $display("[TB] reset during a=200 conversion: dones_after=%0d", dc);
    check("mid-rst no done", dc, 0);
    check_display("after-rst", 8'hFF, 8'hFF, 8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Sequencing controller for the 3-digit decimal 7-segment display path. It accepts an 8-bit binary value through a load handshake and converts it to BCD with a multi-cycle shift-and-add-3 sequencer. It commits the result atomically to the display registers and time-multiplexes the three digits onto the shared segment bus, with leading-zero blanking. It replaces the free-running divider, counter and mux chain with one scheduled block.

## Interface
Parameters:
- SCAN_DIV, 50000: clocks per digit slot; legal range ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- load  in  1  request to convert `a`; sampled only when busy=0
- a  in  8  unsigned binary value, 0..255
- busy  out  1  conversion in progress; load ignored while high
- done  out  1  one-cycle pulse; new value now on display registers
- seg_sel  out  6  active-low digit enables; bit0=ones, bit1=tens, bit2=hundreds, bits5:3 always 1
- seg_led  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on load=1, capture `a` into the shift register, clear the BCD shadow, set iter=0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every shadow nibble ≥5, then shift {shadow,bin} left 1; iter++; after the 8th shift go to COMMIT.
  - COMMIT: copy shadow (hund, tens, ones, 4 bits each) to the display registers; go to IDLE; done=1 in the following cycle.
- `busy` = (state != IDLE).
- `load` while busy is ignored; it is not queued.
- Display registers change only in COMMIT; the displayed value never shows a partial result.
- Scan: prescaler counts 0..SCAN_DIV-1. At wrap, the digit index advances 0→1→2→0. The scan runs independently of the FSM.
- Blanking:
  - Hundreds is blanked when hund==0.
  - Tens is blanked when hund==0 and tens==0.
  - Ones is never blanked.
  - A blanked digit keeps its seg_sel asserted and drives seg_led=8'hFF.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any nibble >9 gives FF (unreachable).

## Timing
- Load sampled at edge E0. SHIFT occupies the cycles after E0..E7. COMMIT is the cycle after E8. The display registers take the new value at E9. done=1 for the cycle after E9, with the FSM in IDLE.
- busy is high for exactly 9 cycles; load→done latency is 10 edges.
- load=1 during the done cycle is accepted (FSM is in IDLE).
- seg_sel and seg_led are registered: they reflect the digit index and display registers of the previous cycle, i.e. 1 cycle behind an index advance or a commit.
- With SCAN_DIV=1 the digit advances every cycle.
- Reset (async, any state, including mid-SHIFT):
  - state=IDLE, busy=0, done=0, in-progress conversion discarded.
  - display registers=0, prescaler=0, digit index=0.
  - seg_sel=6'b111110, seg_led=8'hC0.

## Structure
- Shared package `seg_pkg`: FSM state enum, segment code constants SEG_0..SEG_9 and SEG_BLANK, NUM_DIGITS=3, SEL_OFF=6'h3F.
- One sub-module, `bcd_seq_conv`. It contains the iterative double-dabble datapath, the iteration counter and the FSM, with ports load/a/busy/commit/bcd[11:0].
- The top level holds the display registers, the scan prescaler, the digit index, the blanking logic and the output registers.

## Test plan
- Reset release → seg_sel=111110, seg_led=C0, busy=0, done=0. With SCAN_DIV=4, hundreds and tens show FF and ones shows C0.
- Load a=255 (SCAN_DIV=4) → busy high 9 cycles, done at edge 10. Scan cycle gives: ones sel 111110/led 92, tens 111101/92, hundreds 111011/A4.
- Load a=7 → hundreds and tens slots drive FF, ones drives F8. Load a=105 → tens drives C0 (not blanked), hundreds F9, ones 92.
- Load a=42, then load a=99 on the 3rd busy cycle → ignored: one done pulse, display 42. Load a=99 during the done cycle → accepted, display 99 ten cycles later.
- Assert rst in the 5th SHIFT cycle of a=200 after a prior value of 42 → outputs immediately at reset values, display shows 0, no done pulse, and 42 is not restored.
